// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared definitions for the instruction fetch unit: FSM state encoding,
//   the NOP presented to decode out of reset, and the sequential PC step.
package fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DROP = 3'd4
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/fetch_redirect_mux.sv
// fetch_redirect_mux
//   Combinational selection of the redirect target. Branch and JALR resolve
//   in execute and are older than a JAL in decode, so the order is
//   branch > jalr > jal; a lower-priority request in the same cycle is lost.
//
// Ports
//   branch, branch_target : taken branch from execute
//   jalr,   JALR_target   : JALR from execute
//   jal,    JAL_target    : JAL from decode
//   redirect              : any redirect this cycle
//   target                : selected destination
module fetch_redirect_mux
    import fetch_pkg::*;
#(
    parameter int ADDRESS_BITS = 32
) (
    input  logic                    branch,
    input  logic [ADDRESS_BITS-1:0] branch_target,
    input  logic                    jalr,
    input  logic [ADDRESS_BITS-1:0] JALR_target,
    input  logic                    jal,
    input  logic [ADDRESS_BITS-1:0] JAL_target,
    output logic                    redirect,
    output logic [ADDRESS_BITS-1:0] target
);

    always_comb begin
        redirect = branch | jalr | jal;
        target   = JAL_target;
        if (branch) begin
            target = branch_target;
        end else if (jalr) begin
            target = JALR_target;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//   Single-outstanding instruction fetch engine. Issues one request at a
//   time to instruction memory, hands each response to decode with its PC,
//   holds it while decode stalls, and squashes in-flight fetches on redirect.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | one cycle after reset; also the halt state after a misaligned
//          | redirect (misaligned=1, no requests)
//   REQ    | i_mem_read=1 at PC, waiting for i_mem_ready
//   WAIT   | request accepted, waiting for i_mem_valid
//   HOLD   | instruction presented to decode, held while stall=1
//   DROP   | a redirect orphaned the outstanding request; swallow its reply
//
// Ports
//   clock, reset (sync, active low)
//   stall                          : decode back-pressure
//   branch/jalr/jal + *_target     : redirect requests
//   i_mem_read, i_mem_read_address : request channel (i_mem_ready accepts)
//   i_mem_valid, i_mem_data        : response channel
//   instruction, inst_PC, inst_valid : to decode
//   misaligned                     : misaligned redirect trap flag
//   scan                           : enables the per-cycle trace
//
// Build option
//   FETCH_MISALIGN_TRAP_EN : when defined, a redirect target with nonzero
//   bits [1:0] halts fetch and raises misaligned until reset or an aligned
//   redirect. When undefined, the low target bits are simply cleared and
//   misaligned is tied low.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                      CORE            = 0,
    parameter int                      ADDRESS_BITS    = 32,
    parameter int                      DATA_WIDTH      = 32,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC        = '0,
    parameter int                      SCAN_CYCLES_MIN = 0,
    parameter int                      SCAN_CYCLES_MAX = 1000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    branch,
    input  logic [ADDRESS_BITS-1:0] branch_target,
    input  logic                    jalr,
    input  logic [ADDRESS_BITS-1:0] JALR_target,
    input  logic                    jal,
    input  logic [ADDRESS_BITS-1:0] JAL_target,
    output logic                    i_mem_read,
    output logic [ADDRESS_BITS-1:0] i_mem_read_address,
    input  logic                    i_mem_ready,
    input  logic                    i_mem_valid,
    input  logic [DATA_WIDTH-1:0]   i_mem_data,
    output logic [DATA_WIDTH-1:0]   instruction,
    output logic [ADDRESS_BITS-1:0] inst_PC,
    output logic                    inst_valid,
    output logic                    misaligned,
    input  logic                    scan
);

    fetch_state_t            state;
    logic [ADDRESS_BITS-1:0] pc;
    logic                    redirect;
    logic [ADDRESS_BITS-1:0] target_raw;
    logic [ADDRESS_BITS-1:0] target_eff;
    logic                    bad_target;
    logic                    misaligned_q;
    int                      scan_cycles;

    fetch_redirect_mux #(
        .ADDRESS_BITS (ADDRESS_BITS)
    ) u_redirect_mux (
        .branch        (branch),
        .branch_target (branch_target),
        .jalr          (jalr),
        .JALR_target   (JALR_target),
        .jal           (jal),
        .JAL_target    (JAL_target),
        .redirect      (redirect),
        .target        (target_raw)
    );

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target_eff = target_raw;
    assign bad_target = redirect && (target_raw[1:0] != 2'b00);
    assign misaligned = misaligned_q;
`else
    assign target_eff = target_raw & ~ADDRESS_BITS'(3);
    assign bad_target = 1'b0;
    assign misaligned = 1'b0;
`endif

    // PC only moves on acceptance-driven advance or redirect, so the request
    // address is stable for as long as REQ waits on i_mem_ready.
    assign i_mem_read         = (state == S_REQ);
    assign i_mem_read_address = pc;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            inst_valid   <= 1'b0;
            instruction  <= DATA_WIDTH'(NOP_INSTR);
            inst_PC      <= RESET_PC;
            misaligned_q <= 1'b0;
            scan_cycles  <= 0;
        end else begin
            if (scan_cycles <= SCAN_CYCLES_MAX) begin
                scan_cycles <= scan_cycles + 1;
            end
            inst_valid <= 1'b0;

            if (bad_target) begin
                state        <= S_IDLE;
                misaligned_q <= 1'b1;
            end else if (redirect) begin
                // Redirect wins over stall; a request already accepted but
                // not yet answered must have its reply swallowed in DROP.
                pc           <= target_eff;
                misaligned_q <= 1'b0;
                case (state)
                    S_REQ:   state <= i_mem_ready ? S_DROP : S_REQ;
                    S_WAIT:  state <= i_mem_valid ? S_REQ : S_DROP;
                    S_DROP:  state <= i_mem_valid ? S_REQ : S_DROP;
                    default: state <= S_REQ;
                endcase
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!misaligned_q) begin
                            state <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        if (i_mem_ready) begin
                            state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (i_mem_valid) begin
                            instruction <= i_mem_data;
                            inst_PC     <= pc;
                            inst_valid  <= 1'b1;
                            pc          <= pc + ADDRESS_BITS'(PC_INC);
                            state       <= stall ? S_HOLD : S_REQ;
                        end
                    end
                    S_HOLD: begin
                        if (stall) begin
                            inst_valid <= 1'b1;
                        end else begin
                            state <= S_REQ;
                        end
                    end
                    S_DROP: begin
                        if (i_mem_valid) begin
                            state <= S_REQ;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (reset && scan && scan_cycles >= SCAN_CYCLES_MIN && scan_cycles <= SCAN_CYCLES_MAX) begin
            $display("fetch_unit[%0d] cycle=%0d state=%s pc=%h redirect=%b inst_valid=%b",
                     CORE, scan_cycles, state.name(), pc, redirect, inst_valid);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Directed table from reset, hand sequences for the multi-cycle corners,
//   then randomized traffic checked against a program-order stream model.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam int AB = 32;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          stall;
    logic          branch;
    logic [AB-1:0] branch_target;
    logic          jalr;
    logic [AB-1:0] JALR_target;
    logic          jal;
    logic [AB-1:0] JAL_target;
    logic          i_mem_read;
    logic [AB-1:0] i_mem_read_address;
    logic          i_mem_ready;
    logic          i_mem_valid;
    logic [DW-1:0] i_mem_data;
    logic [DW-1:0] instruction;
    logic [AB-1:0] inst_PC;
    logic          inst_valid;
    logic          misaligned;
    logic          scan;

    int n_checks = 0;
    int n_pass   = 0;

    // bench memory state
    bit            mem_auto;
    bit            pending;
    int            resp_cnt;
    logic [31:0]   pend_addr;
    int            lat_min;
    int            lat_max;

    fetch_unit #(
        .CORE            (0),
        .ADDRESS_BITS    (AB),
        .DATA_WIDTH      (DW),
        .RESET_PC        ('0),
        .SCAN_CYCLES_MIN (0),
        .SCAN_CYCLES_MAX (1000)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .stall              (stall),
        .branch             (branch),
        .branch_target      (branch_target),
        .jalr               (jalr),
        .JALR_target        (JALR_target),
        .jal                (jal),
        .JAL_target         (JAL_target),
        .i_mem_read         (i_mem_read),
        .i_mem_read_address (i_mem_read_address),
        .i_mem_ready        (i_mem_ready),
        .i_mem_valid        (i_mem_valid),
        .i_mem_data         (i_mem_data),
        .instruction        (instruction),
        .inst_PC            (inst_PC),
        .inst_valid         (inst_valid),
        .misaligned         (misaligned),
        .scan               (scan)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return ~a ^ 32'h0F0F_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic        acc;
        logic [31:0] acc_addr;
        logic        was_valid;
        acc       = i_mem_read && i_mem_ready;
        acc_addr  = i_mem_read_address;
        was_valid = i_mem_valid;
        @(posedge clock);
        #1;
        if (mem_auto) begin
            if (was_valid) begin
                i_mem_valid = 1'b0;
                pending     = 1'b0;
            end
            if (acc) begin
                pending   = 1'b1;
                pend_addr = acc_addr;
                resp_cnt  = int'($urandom_range(lat_max, lat_min));
            end
            if (pending && !i_mem_valid) begin
                resp_cnt--;
                if (resp_cnt <= 0) begin
                    i_mem_valid = 1'b1;
                    i_mem_data  = mem_f(pend_addr);
                end
            end
        end
    endtask

    task automatic clear_redirects();
        branch = 1'b0; jalr = 1'b0; jal = 1'b0;
        branch_target = '0; JALR_target = '0; JAL_target = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        stall = 1'b0;
        scan  = 1'b0;
        clear_redirects();
        i_mem_ready = 1'b0;
        i_mem_valid = 1'b0;
        i_mem_data  = '0;
        pending     = 1'b0;
        tick();
        tick();
        pending     = 1'b0;
        i_mem_valid = 1'b0;
        reset = 1'b1;
    endtask

    typedef struct {
        logic        s;
        logic        b;
        logic [31:0] bt;
        logic        jr;
        logic [31:0] jrt;
        logic        jl;
        logic [31:0] jlt;
        logic        e_read;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] bt,
                                input logic jr, input logic [31:0] jrt,
                                input logic jl, input logic [31:0] jlt,
                                input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ep);
        vec_t v;
        v.s = s; v.b = b; v.bt = bt; v.jr = jr; v.jrt = jrt; v.jl = jl; v.jlt = jlt;
        v.e_read = er; v.e_addr = ea; v.e_iv = ev; v.e_pc = ep;
        return v;
    endfunction

    initial begin
        vec_t        vecs[$];
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        logic [31:0] tmask;
        logic        red;
        logic        pre_read, pre_ready, pre_stall, pre_iv;
        logic [31:0] pre_addr, pre_ipc, pre_instr;
        int          n_deliv;

        // stall br  bt            jr  jrt       jl  jlt       read addr          iv  inst_PC
        vecs.push_back(mk(0, 0, 0,            0, 0,        0, 0,        0, 0,            0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0,        0, 0,        1, 32'h0,        0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0,        0, 0,        0, 0,            0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0,        0, 0,        1, 32'h4,        1, 32'h0));
        vecs.push_back(mk(0, 0, 0,            0, 0,        0, 0,        0, 0,            0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0,        0, 0,        1, 32'h8,        1, 32'h4));
        vecs.push_back(mk(1, 0, 0,            0, 0,        0, 0,        0, 0,            0, 0));
        vecs.push_back(mk(1, 0, 0,            0, 0,        0, 0,        0, 0,            1, 32'h8));
        vecs.push_back(mk(1, 0, 0,            0, 0,        0, 0,        0, 0,            1, 32'h8));
        vecs.push_back(mk(0, 0, 0,            0, 0,        0, 0,        0, 0,            1, 32'h8));
        vecs.push_back(mk(0, 0, 0,            0, 0,        0, 0,        1, 32'hC,        0, 0));
        vecs.push_back(mk(0, 1, 32'h100,      0, 0,        0, 0,        0, 0,            0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0,        0, 0,        1, 32'h100,      0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0,        0, 0,        0, 0,            0, 0));
        vecs.push_back(mk(0, 1, 32'h200,      1, 32'h300, 1, 32'h400, 1, 32'h104,      1, 32'h100));
        vecs.push_back(mk(0, 0, 0,            0, 0,        0, 0,        0, 0,            0, 0));
        vecs.push_back(mk(0, 1, 32'hFFFFFFFC, 0, 0,        0, 0,        1, 32'h200,      0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0,        0, 0,        0, 0,            0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0,        0, 0,        1, 32'hFFFFFFFC, 0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0,        0, 0,        0, 0,            0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0,        0, 0,        1, 32'h0,        1, 32'hFFFFFFFC));
        vecs.push_back(mk(0, 0, 0,            0, 0,        0, 0,        0, 0,            0, 0));
        vecs.push_back(mk(0, 0, 0,            1, 32'h300, 1, 32'h400, 1, 32'h4,        1, 32'h0));
        vecs.push_back(mk(0, 0, 0,            0, 0,        0, 0,        0, 0,            0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0,        1, 32'h400, 1, 32'h300,      0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0,        0, 0,        0, 0,            0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0,        0, 0,        1, 32'h400,      0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0,        0, 0,        0, 0,            0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0,        0, 0,        1, 32'h404,      1, 32'h400));

        // ---- reset state ----
        mem_auto = 1'b1;
        lat_min  = 1;
        lat_max  = 1;
        do_reset();
        check("rst_read",       {31'd0, i_mem_read}, 32'd0);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_instruction", instruction, 32'h0000_0013);
        check("rst_inst_pc",     inst_PC, 32'h0);
        check("rst_misaligned", {31'd0, misaligned}, 32'd0);

        // ---- directed table, always-ready memory, 1-cycle response ----
        i_mem_ready = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            stall         = vecs[i].s;
            branch        = vecs[i].b;
            branch_target = vecs[i].bt;
            jalr          = vecs[i].jr;
            JALR_target   = vecs[i].jrt;
            jal           = vecs[i].jl;
            JAL_target    = vecs[i].jlt;
            scan          = (i < 3);
            check($sformatf("tbl%0d_read", i), {31'd0, i_mem_read}, {31'd0, vecs[i].e_read});
            if (vecs[i].e_read) check($sformatf("tbl%0d_addr", i), i_mem_read_address, vecs[i].e_addr);
            check($sformatf("tbl%0d_iv", i), {31'd0, inst_valid}, {31'd0, vecs[i].e_iv});
            if (vecs[i].e_iv) begin
                check($sformatf("tbl%0d_pc", i), inst_PC, vecs[i].e_pc);
                check($sformatf("tbl%0d_instr", i), instruction, mem_f(vecs[i].e_pc));
            end
            check($sformatf("tbl%0d_mis", i), {31'd0, misaligned}, 32'd0);
            tick();
        end
        clear_redirects();
        stall = 1'b0;
        scan  = 1'b0;

        // ---- misaligned redirect ----
        do_reset();
        tick();
        check("mis_req0", i_mem_read_address, 32'h0);
        jalr = 1'b1; JALR_target = 32'h102;
        tick();
        clear_redirects();
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_flag",  {31'd0, misaligned}, 32'd1);
        check("mis_noreq", {31'd0, i_mem_read}, 32'd0);
        tick();
        tick();
        check("mis_halt_flag",  {31'd0, misaligned}, 32'd1);
        check("mis_halt_noreq", {31'd0, i_mem_read}, 32'd0);
        jal = 1'b1; JAL_target = 32'h40;
        tick();
        clear_redirects();
        check("mis_clear", {31'd0, misaligned}, 32'd0);
        check("mis_read",  {31'd0, i_mem_read}, 32'd1);
        check("mis_addr",  i_mem_read_address, 32'h40);
`else
        check("mis_flag", {31'd0, misaligned}, 32'd0);
        check("mis_read", {31'd0, i_mem_read}, 32'd1);
        check("mis_addr", i_mem_read_address, 32'h100);
`endif

        // ---- reset mid-request, stale response afterwards ----
        mem_auto = 1'b0;
        do_reset();
        tick();
        i_mem_ready = 1'b1;
        tick();
        i_mem_ready = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        i_mem_valid = 1'b1; i_mem_data = 32'hDEAD_BEEF;
        tick();
        i_mem_valid = 1'b0;
        check("stale_iv",   {31'd0, inst_valid}, 32'd0);
        check("stale_read", {31'd0, i_mem_read}, 32'd1);
        check("stale_addr", i_mem_read_address, 32'h0);
        tick();
        check("stale_iv2",   {31'd0, inst_valid}, 32'd0);
        check("stale_instr", instruction, 32'h0000_0013);

        // ---- redirect in WAIT, second redirect in DROP, redirect beats stall ----
        do_reset();
        tick();
        i_mem_ready = 1'b1;
        tick();
        i_mem_ready = 1'b0;
        branch = 1'b1; branch_target = 32'h500;
        tick();
        clear_redirects();
        check("drop_read", {31'd0, i_mem_read}, 32'd0);
        check("drop_iv",   {31'd0, inst_valid}, 32'd0);
        jal = 1'b1; JAL_target = 32'h600;
        tick();
        clear_redirects();
        check("drop2_read", {31'd0, i_mem_read}, 32'd0);
        i_mem_valid = 1'b1; i_mem_data = 32'hBAD0_0BAD;
        tick();
        i_mem_valid = 1'b0;
        check("drop_iv_after", {31'd0, inst_valid}, 32'd0);
        check("drop_next_read", {31'd0, i_mem_read}, 32'd1);
        check("drop_next_addr", i_mem_read_address, 32'h600);
        i_mem_ready = 1'b1;
        tick();
        i_mem_ready = 1'b0;
        i_mem_valid = 1'b1; i_mem_data = mem_f(32'h600);
        stall = 1'b1;
        branch = 1'b1; branch_target = 32'h700;
        tick();
        i_mem_valid = 1'b0;
        stall = 1'b0;
        clear_redirects();
        check("redir_stall_iv",   {31'd0, inst_valid}, 32'd0);
        check("redir_stall_read", {31'd0, i_mem_read}, 32'd1);
        check("redir_stall_addr", i_mem_read_address, 32'h700);

        // ---- randomized traffic against a program-order stream model ----
        mem_auto = 1'b1;
        lat_min  = 1;
        lat_max  = 3;
`ifdef FETCH_MISALIGN_TRAP_EN
        tmask = 32'hFFFF_FFFC;
`else
        tmask = 32'hFFFF_FFFF;
`endif
        do_reset();
        exp_pc  = 32'h0;
        n_deliv = 0;
        for (int c = 0; c < 4000; c++) begin
            stall         = ($urandom_range(99) < 30);
            branch        = ($urandom_range(31) == 0);
            jalr          = ($urandom_range(31) == 0);
            jal           = ($urandom_range(31) == 0);
            branch_target = $urandom() & tmask;
            JALR_target   = $urandom() & tmask;
            JAL_target    = $urandom() & tmask;
            i_mem_ready   = ($urandom_range(99) < 70);

            red = branch | jalr | jal;
            if (branch)      tgt = branch_target;
            else if (jalr)   tgt = JALR_target;
            else             tgt = JAL_target;
            pre_read  = i_mem_read;
            pre_addr  = i_mem_read_address;
            pre_ready = i_mem_ready;
            pre_stall = stall;
            pre_iv    = inst_valid;
            pre_ipc   = inst_PC;
            pre_instr = instruction;

            tick();

            if (red) begin
                check("rnd_redirect_kill", {31'd0, inst_valid}, 32'd0);
                exp_pc = tgt & 32'hFFFF_FFFC;
            end else if (inst_valid && !pre_iv) begin
                check("rnd_deliver_pc", inst_PC, exp_pc);
                check("rnd_deliver_instr", instruction, mem_f(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_deliv++;
            end else if (inst_valid && pre_iv) begin
                check("rnd_hold_needs_stall", {31'd0, pre_stall}, 32'd1);
                check("rnd_hold_pc", inst_PC, pre_ipc);
                check("rnd_hold_instr", instruction, pre_instr);
            end
            if (pre_read && !pre_ready && !red) begin
                check("rnd_req_stable_read", {31'd0, i_mem_read}, 32'd1);
                check("rnd_req_stable_addr", i_mem_read_address, pre_addr);
            end
            if (i_mem_read) begin
                check("rnd_one_outstanding", {31'd0, pending}, 32'd0);
            end
            check("rnd_misaligned", {31'd0, misaligned}, 32'd0);
        end
        check("rnd_progress", {31'd0, (n_deliv >= 50)}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
